// File: rtl/shower_ctrl_if.sv
// -----------------------------------------------------------------------------
// shower_ctrl_if
// Configuration bus between a host and the shower controller.
//   cfg_we      host -> ctrl  shadow write strobe
//   cfg_sel     host -> ctrl  shadow select: 0 loose, 1 nominal, 2 tight, 3 ignored
//   cfg_data    host -> ctrl  shadow write data (TH_W bits)
//   cfg_commit  host -> ctrl  request to apply the shadow set to the live thresholds
//   cfg_busy    ctrl -> host  commit pending or post-commit blanking in progress
//   cfg_err     ctrl -> host  sticky: last commit rejected for bad ordering
// Modports: master (host side), slave (controller side).
// -----------------------------------------------------------------------------
interface shower_ctrl_if #(
   parameter int TH_W = 10
);
   logic            cfg_we;
   logic [1:0]      cfg_sel;
   logic [TH_W-1:0] cfg_data;
   logic            cfg_commit;
   logic            cfg_busy;
   logic            cfg_err;

   modport master (
      output cfg_we, cfg_sel, cfg_data, cfg_commit,
      input  cfg_busy, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_sel, cfg_data, cfg_commit,
      output cfg_busy, cfg_err
   );
endinterface

// File: rtl/shower_ctrl.sv
// -----------------------------------------------------------------------------
// shower_ctrl
// Controller and scheduler for the anode shower-detection datapath.
//  - Holds live loose/nominal/tight hit-count thresholds. Updates go through a
//    shadow register set and are applied atomically on commit, after an
//    ordering check (loose <= nominal <= tight).
//  - Qualifies the per-BX 2-bit shower code into a one-cycle fire strobe with a
//    programmable holdoff, and blanks triggering for BLANK_CYC cycles after a
//    threshold change so the datapath pipeline can settle.
//  - Keeps saturating per-level counters of fired events.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            1 = new fires allowed
//   shower_int[1:0]   datapath code: 0 none, 1 loose, 2 nominal, 3 tight
//   holdoff[3:0]      dead cycles after each fire, sampled on FIRE entry
//   cfg               configuration bus (shower_ctrl_if.slave)
//   cnt_clr           clear all rate counters
//   th_loose/th_nominal/th_tight  live thresholds (registered)
//   shower_out, shower_valid      qualified code and one-cycle fire strobe
//   cnt_loose/cnt_nom/cnt_tight   saturating fired-event counters
// -----------------------------------------------------------------------------
module shower_ctrl #(
   parameter int              TH_W         = 10,
   parameter int              CNT_W        = 16,
   parameter int              BLANK_CYC    = 6,
   parameter logic [TH_W-1:0] TH_LOOSE_DEF = TH_W'(20),
   parameter logic [TH_W-1:0] TH_NOM_DEF   = TH_W'(40),
   parameter logic [TH_W-1:0] TH_TIGHT_DEF = TH_W'(80)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       shower_int,
   input  logic [3:0]       holdoff,
   shower_ctrl_if.slave     cfg,
   input  logic             cnt_clr,
   output logic [TH_W-1:0]  th_loose,
   output logic [TH_W-1:0]  th_nominal,
   output logic [TH_W-1:0]  th_tight,
   output logic [1:0]       shower_out,
   output logic             shower_valid,
   output logic [CNT_W-1:0] cnt_loose,
   output logic [CNT_W-1:0] cnt_nom,
   output logic [CNT_W-1:0] cnt_tight
);

   // Shared down-counter for HOLD and BLANK; wide enough for both loads.
   localparam int TW = ($clog2(BLANK_CYC) > 4) ? $clog2(BLANK_CYC) : 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRE  = 2'd1,
      HOLD  = 2'd2,
      BLANK = 2'd3
   } state_t;

   state_t          state_reg,   state_next;
   logic [TW-1:0]   timer_reg,   timer_next;
   logic [1:0]      code_reg,    code_next;
   logic [3:0]      hold_reg,    hold_next;
   logic            pending_reg;
   logic            err_reg;

   logic            busy;
   logic            order_ok;
   logic            apply_ok;
   logic            apply_bad;

   logic [TH_W-1:0] shadow_loose, shadow_nom, shadow_tight;

   // -------------------------------------------------------------------------
   // Per-level storage: shadow threshold, live threshold, rate counter.
   // Level gi serves shower code gi+1.
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_lvl
         localparam logic [TH_W-1:0] DEF = (gi == 0) ? TH_LOOSE_DEF :
                                           (gi == 1) ? TH_NOM_DEF   : TH_TIGHT_DEF;

         logic [TH_W-1:0]  shadow_reg;
         logic [TH_W-1:0]  live_reg;
         logic [CNT_W-1:0] cnt_reg;

         // Writes are dropped while a commit is pending or blanking runs, so
         // the shadow set that gets applied cannot change under the check.
         always_ff @(posedge clk) begin
            if (rst) begin
               shadow_reg <= DEF;
            end else if (cfg.cfg_we && !busy && cfg.cfg_sel == 2'(gi)) begin
               shadow_reg <= cfg.cfg_data;
            end
         end

         // Live thresholds move only when a checked commit is applied.
         always_ff @(posedge clk) begin
            if (rst) begin
               live_reg <= DEF;
            end else if (apply_ok) begin
               live_reg <= shadow_reg;
            end
         end

         // Clear wins over a same-cycle increment; saturate at all-ones.
         always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
               cnt_reg <= '0;
            end else if (state_reg == FIRE && code_reg == 2'(gi + 1) && cnt_reg != '1) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end
      end
   endgenerate

   assign shadow_loose = g_lvl[0].shadow_reg;
   assign shadow_nom   = g_lvl[1].shadow_reg;
   assign shadow_tight = g_lvl[2].shadow_reg;

   assign th_loose   = g_lvl[0].live_reg;
   assign th_nominal = g_lvl[1].live_reg;
   assign th_tight   = g_lvl[2].live_reg;

   assign cnt_loose = g_lvl[0].cnt_reg;
   assign cnt_nom   = g_lvl[1].cnt_reg;
   assign cnt_tight = g_lvl[2].cnt_reg;

   assign order_ok = (shadow_loose <= shadow_nom) && (shadow_nom <= shadow_tight);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         timer_reg <= '0;
         code_reg  <= '0;
         hold_reg  <= '0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         code_reg  <= code_next;
         hold_reg  <= hold_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic. A fire takes priority over applying a pending
   // commit; the commit simply waits for the next quiet IDLE cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      code_next  = code_reg;
      hold_next  = hold_reg;
      apply_ok   = 1'b0;
      apply_bad  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (enable && shower_int != 2'd0) begin
               state_next = FIRE;
               code_next  = shower_int;
               hold_next  = holdoff;
            end else if (pending_reg) begin
               if (order_ok) begin
                  apply_ok   = 1'b1;
                  state_next = BLANK;
                  timer_next = TW'(BLANK_CYC - 1);
               end else begin
                  apply_bad  = 1'b1;
               end
            end
         end

         FIRE: begin
            if (hold_reg == 4'd0) begin
               state_next = IDLE;
            end else begin
               state_next = HOLD;
               timer_next = TW'(hold_reg) - TW'(1);
            end
         end

         HOLD, BLANK: begin
            if (timer_reg == '0) begin
               state_next = IDLE;
            end else begin
               timer_next = timer_reg - TW'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      shower_valid = 1'b0;
      shower_out   = 2'd0;
      if (state_reg == FIRE) begin
         shower_valid = 1'b1;
         shower_out   = code_reg;
      end
      busy         = pending_reg || (state_reg == BLANK);
      cfg.cfg_busy = busy;
      cfg.cfg_err  = err_reg;
   end

   // -------------------------------------------------------------------------
   // Commit handshake. A commit while one is already pending is absorbed; the
   // apply/reject decision always consumes the pending request.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg <= 1'b0;
      end else if (apply_ok || apply_bad) begin
         pending_reg <= 1'b0;
      end else if (cfg.cfg_commit) begin
         pending_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (apply_ok) begin
         err_reg <= 1'b0;
      end else if (apply_bad) begin
         err_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_shower_ctrl.sv
module tb_shower_ctrl;

   localparam int TH_W  = 10;
   localparam int CNT_W = 6;   // narrow counters so saturation is reachable quickly

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic [1:0]       shower_int;
   logic [3:0]       holdoff;
   logic             cnt_clr;
   logic [TH_W-1:0]  th_loose, th_nominal, th_tight;
   logic [1:0]       shower_out;
   logic             shower_valid;
   logic [CNT_W-1:0] cnt_loose, cnt_nom, cnt_tight;

   int n_cmp = 0;
   int n_err = 0;

   shower_ctrl_if #(.TH_W(TH_W)) cfg_bus ();

   shower_ctrl #(
      .TH_W      (TH_W),
      .CNT_W     (CNT_W),
      .BLANK_CYC (6)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .shower_int   (shower_int),
      .holdoff      (holdoff),
      .cfg          (cfg_bus),
      .cnt_clr      (cnt_clr),
      .th_loose     (th_loose),
      .th_nominal   (th_nominal),
      .th_tight     (th_tight),
      .shower_out   (shower_out),
      .shower_valid (shower_valid),
      .cnt_loose    (cnt_loose),
      .cnt_nom      (cnt_nom),
      .cnt_tight    (cnt_tight)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; shower_int = 2'd0; holdoff = 4'd0; cnt_clr = 1'b0;
      cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_sel = 2'd0; cfg_bus.cfg_data = '0;
      cfg_bus.cfg_commit = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // ---- reset state ----
      chk("rst_valid", 32'(shower_valid), 0);
      chk("rst_out",   32'(shower_out), 0);
      chk("rst_busy",  32'(cfg_bus.cfg_busy), 0);
      chk("rst_err",   32'(cfg_bus.cfg_err), 0);
      chk("rst_thl",   32'(th_loose), 20);
      chk("rst_thn",   32'(th_nominal), 40);
      chk("rst_tht",   32'(th_tight), 80);
      chk("rst_cnt",   32'(cnt_loose) + 32'(cnt_nom) + 32'(cnt_tight), 0);
      $display("step reset: valid=%0d busy=%0d th=%0d/%0d/%0d", shower_valid,
               cfg_bus.cfg_busy, th_loose, th_nominal, th_tight);

      // ---- fire with holdoff=3, no retrigger during HOLD ----
      enable = 1'b1; holdoff = 4'd3;
      tick(); tick();
      shower_int = 2'd2;
      tick();
      chk("fire1_valid", 32'(shower_valid), 1);
      chk("fire1_out",   32'(shower_out), 2);
      $display("step fire nominal: valid=%0d out=%0d", shower_valid, shower_out);
      shower_int = 2'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_novalid", 32'(shower_valid), 0);
         chk("hold_out0",    32'(shower_out), 0);
      end
      tick();
      chk("hold_end_idle", 32'(shower_valid), 0);
      shower_int = 2'd1;
      tick();
      chk("fire2_valid", 32'(shower_valid), 1);
      chk("fire2_out",   32'(shower_out), 1);
      shower_int = 2'd0;
      tick();
      chk("cnt_nom_1",   32'(cnt_nom), 1);
      chk("cnt_loose_1", 32'(cnt_loose), 1);
      $display("step fire loose: cnt_nom=%0d cnt_loose=%0d", cnt_nom, cnt_loose);
      tick(); tick(); tick();

      // ---- holdoff=0, tight held: IDLE/FIRE alternate ----
      holdoff = 4'd0; shower_int = 2'd3;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("alt_fire", 32'(shower_valid), 1);
         chk("alt_out",  32'(shower_out), 3);
         tick();
         chk("alt_idle", 32'(shower_valid), 0);
         chk("alt_cnt",  32'(cnt_tight), 32'(i + 1));
         $display("step alternate %0d: cnt_tight=%0d", i, cnt_tight);
      end
      shower_int = 2'd0;

      // ---- valid commit 30/50/90, blanking, dropped writes ----
      cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_sel = 2'd0; cfg_bus.cfg_data = 10'd30;
      tick();
      cfg_bus.cfg_sel = 2'd1; cfg_bus.cfg_data = 10'd50;
      tick();
      cfg_bus.cfg_sel = 2'd2; cfg_bus.cfg_data = 10'd90; cfg_bus.cfg_commit = 1'b1;
      tick();
      cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_commit = 1'b0;
      chk("pend_busy", 32'(cfg_bus.cfg_busy), 1);
      chk("pend_thl",  32'(th_loose), 20);
      tick();
      chk("apply_thl",  32'(th_loose), 30);
      chk("apply_thn",  32'(th_nominal), 50);
      chk("apply_tht",  32'(th_tight), 90);
      chk("apply_busy", 32'(cfg_bus.cfg_busy), 1);
      $display("step commit: th=%0d/%0d/%0d busy=%0d", th_loose, th_nominal, th_tight,
               cfg_bus.cfg_busy);
      shower_int = 2'd1;
      cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_sel = 2'd0; cfg_bus.cfg_data = 10'd5;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("blank_busy",    32'(cfg_bus.cfg_busy), 1);
         chk("blank_novalid", 32'(shower_valid), 0);
      end
      shower_int = 2'd0; cfg_bus.cfg_we = 1'b0;
      tick();
      chk("blank_end_busy", 32'(cfg_bus.cfg_busy), 0);
      chk("blank_end_valid", 32'(shower_valid), 0);
      // Recommit the untouched shadow: loose must stay 30 if the write was dropped.
      cfg_bus.cfg_commit = 1'b1;
      tick();
      cfg_bus.cfg_commit = 1'b0;
      tick();
      chk("drop_thl", 32'(th_loose), 30);
      $display("step dropped write: th_loose=%0d", th_loose);
      repeat (6) tick();
      chk("drop_busy_end", 32'(cfg_bus.cfg_busy), 0);

      // ---- bad ordering, then a good commit clears the error ----
      cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_sel = 2'd0; cfg_bus.cfg_data = 10'd60;
      tick();
      cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_commit = 1'b1;
      tick();
      cfg_bus.cfg_commit = 1'b0;
      chk("bad_busy", 32'(cfg_bus.cfg_busy), 1);
      tick();
      chk("bad_err",      32'(cfg_bus.cfg_err), 1);
      chk("bad_busy_off", 32'(cfg_bus.cfg_busy), 0);
      chk("bad_thl",      32'(th_loose), 30);
      $display("step bad order: err=%0d busy=%0d th_loose=%0d", cfg_bus.cfg_err,
               cfg_bus.cfg_busy, th_loose);
      cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_sel = 2'd0; cfg_bus.cfg_data = 10'd40;
      tick();
      cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_commit = 1'b1;
      tick();
      cfg_bus.cfg_commit = 1'b0;
      tick();
      chk("good_err", 32'(cfg_bus.cfg_err), 0);
      chk("good_thl", 32'(th_loose), 40);
      $display("step good commit: err=%0d th_loose=%0d", cfg_bus.cfg_err, th_loose);
      repeat (6) tick();
      chk("good_busy_end", 32'(cfg_bus.cfg_busy), 0);

      // ---- commit + write coincident with a shower: apply after HOLD ----
      holdoff = 4'd2; shower_int = 2'd2;
      cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_sel = 2'd2; cfg_bus.cfg_data = 10'd100;
      cfg_bus.cfg_commit = 1'b1;
      tick();
      shower_int = 2'd0; cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_commit = 1'b0;
      chk("cc_valid", 32'(shower_valid), 1);
      chk("cc_out",   32'(shower_out), 2);
      chk("cc_busy",  32'(cfg_bus.cfg_busy), 1);
      chk("cc_tht0",  32'(th_tight), 90);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("cc_hold_tht", 32'(th_tight), 90);
      end
      tick();
      chk("cc_apply_tht",  32'(th_tight), 100);
      chk("cc_apply_busy", 32'(cfg_bus.cfg_busy), 1);
      chk("cc_cnt_nom",    32'(cnt_nom), 2);
      $display("step commit during fire: th_tight=%0d cnt_nom=%0d", th_tight, cnt_nom);
      repeat (6) tick();
      chk("cc_busy_end", 32'(cfg_bus.cfg_busy), 0);

      // ---- counter saturation and clear priority ----
      holdoff = 4'd0; shower_int = 2'd1;
      for (int i = 0; i < 61; i++) begin
         tick(); tick();
      end
      chk("sat_pre", 32'(cnt_loose), 62);
      tick(); tick();
      chk("sat_max", 32'(cnt_loose), 63);
      tick(); tick();
      chk("sat_hold", 32'(cnt_loose), 63);
      $display("step saturate: cnt_loose=%0d", cnt_loose);
      tick();
      chk("clr_fire", 32'(shower_valid), 1);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0; shower_int = 2'd0;
      chk("clr_loose", 32'(cnt_loose), 0);
      chk("clr_all",   32'(cnt_nom) + 32'(cnt_tight), 0);
      $display("step clear: cnt=%0d/%0d/%0d", cnt_loose, cnt_nom, cnt_tight);

      // ---- reset during HOLD with a pending commit ----
      holdoff = 4'd5; shower_int = 2'd3;
      tick();
      shower_int = 2'd0; cfg_bus.cfg_commit = 1'b1;
      tick();
      cfg_bus.cfg_commit = 1'b0;
      chk("hrst_busy_pre", 32'(cfg_bus.cfg_busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("hrst_busy",  32'(cfg_bus.cfg_busy), 0);
      chk("hrst_err",   32'(cfg_bus.cfg_err), 0);
      chk("hrst_valid", 32'(shower_valid), 0);
      chk("hrst_thl",   32'(th_loose), 20);
      chk("hrst_thn",   32'(th_nominal), 40);
      chk("hrst_tht",   32'(th_tight), 80);
      shower_int = 2'd2;
      tick();
      shower_int = 2'd0;
      chk("hrst_idle_fire", 32'(shower_valid), 1);
      chk("hrst_idle_out",  32'(shower_out), 2);
      $display("step reset in hold: th=%0d/%0d/%0d fire=%0d", th_loose, th_nominal,
               th_tight, shower_valid);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shower_ctrl.md
Name: shower_ctrl

Overview:
- Controller and scheduler for the anode shower-detection datapath.
- Holds the live loose/nominal/tight hit-count thresholds that drive the datapath. Threshold updates arrive through a shadow-register write/commit handshake and apply atomically.
- Qualifies the datapath's 2-bit per-BX shower code into a trigger pulse with programmable holdoff and post-update blanking.
- Keeps saturating per-level rate counters.

Parameters:
- TH_W, 10, threshold and hit-count width
- CNT_W, 16, rate counter width
- BLANK_CYC, 6, cycles of suppression after a threshold commit (covers datapath pipeline depth)
- TH_LOOSE_DEF, 10'd20, reset value of loose threshold
- TH_NOM_DEF, 10'd40, reset value of nominal threshold
- TH_TIGHT_DEF, 10'd80, reset value of tight threshold

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = triggering allowed
- shower_int  in  2  datapath code per BX: 0 none, 1 loose, 2 nominal, 3 tight
- holdoff  in  4  dead cycles after each fire, sampled on FIRE entry
- cfg_we  in  1  shadow write strobe
- cfg_sel  in  2  0 loose, 1 nominal, 2 tight, 3 ignored
- cfg_data  in  TH_W  shadow write data
- cfg_commit  in  1  request to apply shadow to live thresholds
- cfg_busy  out  1  commit pending or blanking in progress
- cfg_err  out  1  sticky: last commit rejected for bad ordering
- th_loose  out  TH_W  live thresholds to datapath (registered)
- th_nominal  out  TH_W  live thresholds to datapath (registered)
- th_tight  out  TH_W  live thresholds to datapath (registered)
- shower_out  out  2  qualified shower code
- shower_valid  out  1  one-cycle fire strobe
- cnt_clr  in  1  clear all rate counters
- cnt_loose  out  CNT_W  fired-event counter for loose
- cnt_nom  out  CNT_W  fired-event counter for nominal
- cnt_tight  out  CNT_W  fired-event counter for tight

Behaviour:
- Reset:
  - State IDLE; shadow and live thresholds set to the *_DEF values.
  - shower_out=0, shower_valid=0, cfg_busy=0, cfg_err=0, all counters 0, pending flag 0.
  - Reset mid-FIRE, HOLD or BLANK aborts to IDLE with the same values.
- FSM states: IDLE, FIRE, HOLD, BLANK.
- IDLE:
  - If enable=1 and shower_int!=0 at cycle N: go to FIRE. At N+1, shower_out=shower_int(N) and shower_valid=1. Latency is 1 cycle.
  - Else if pending=1: check ordering. If loose<=nominal<=tight in the shadow, copy shadow to live, clear cfg_err, and go to BLANK with counter BLANK_CYC-1. Otherwise set cfg_err, leave live unchanged, and stay in IDLE. pending clears in both cases.
  - A fire has priority over applying a commit; the commit stays pending.
- FIRE:
  - Lasts exactly 1 cycle.
  - If holdoff=0, next state is IDLE. Else go to HOLD with counter holdoff-1.
  - shower_out returns to 0 on leaving FIRE.
- HOLD:
  - shower_int is ignored, so there is no retrigger even on a higher code.
  - Leaves for IDLE when the counter reaches 0. Total dead time is exactly holdoff cycles.
- BLANK:
  - shower_int is ignored.
  - Leaves for IDLE after exactly BLANK_CYC cycles.
- enable=0:
  - Blocks new fires only. A FIRE or HOLD already in progress completes.
- Config writes:
  - cfg_we with cfg_busy=0 writes cfg_data to the shadow selected by cfg_sel on the next cycle.
  - cfg_we while cfg_busy=1 is dropped.
  - cfg_we and cfg_commit in the same cycle: the write lands first and the commit includes it.
  - cfg_commit while already pending is a no-op.
- cfg_busy = pending | (state==BLANK).
- Live thresholds change only on commit application, never in any other state.
- Counters:
  - On each shower_valid cycle, increment the counter for shower_out.
  - Counters saturate at all-ones with no wrap.
  - cnt_clr has priority over a same-cycle increment; the result is 0.

Test Plan:
- Reset, then shower_int=2 at cycle 10 with holdoff=3 → shower_out=2 and shower_valid=1 at cycle 11 only. shower_int=3 on cycles 12–14 is ignored. shower_int=1 at cycle 15 fires at 16; cnt_nom=1, cnt_loose=1.
- holdoff=0 with shower_int=3 held constant → shower_valid at every second cycle (IDLE/FIRE alternate); cnt_tight increments once per fire.
- Write loose=30, nominal=50, tight=90 and commit → cfg_busy is 1 for pending plus 6 BLANK cycles, and live outputs update on the apply cycle. shower_int=1 during BLANK gives no fire; cfg_we during busy leaves the shadow unchanged.
- Commit with loose=60, nominal=50 → cfg_err=1, live unchanged, cfg_busy drops after 1 cycle. A following valid commit clears cfg_err.
- cfg_commit in the same cycle as an IDLE shower → fire at N+1; thresholds apply after HOLD ends, then BLANK runs.
- Preload cnt_loose near all-ones and fire loose twice → counter holds 0xFFFF. cnt_clr coincident with a fire gives 0. rst asserted during HOLD → IDLE and defaults on the next cycle.
